// File: rtl/fib_node_table_pkg.sv
// fib_node_pkg: shared types for the FIB node table.
// node_t field widths are fixed here; fib_node_table's WORD_SIZE and
// POINTER_SIZE must match NODE_WORD_W / NODE_PTR_W.
package fib_node_pkg;

    localparam int NODE_WORD_W = 16;
    localparam int NODE_PTR_W  = 16;

    typedef enum logic [2:0] {
        OP_ALLOC     = 3'd0,
        OP_WRITE     = 3'd1,
        OP_SET_LEFT  = 3'd2,
        OP_SET_RIGHT = 3'd3,
        OP_READ      = 3'd4,
        OP_FREE      = 3'd5
    } op_e;

    typedef struct packed {
        logic [NODE_WORD_W-1:0] data;
        logic [NODE_PTR_W-1:0]  left;
        logic [NODE_PTR_W-1:0]  right;
        logic                   valid;
        logic                   lvalid;
        logic                   rvalid;
    } node_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/fib_node_table_if.sv
// Command/response bus of the FIB node table. master = controller, slave = table.
interface fib_node_table_if #(
    parameter int WORD_SIZE    = 16,
    parameter int POINTER_SIZE = 16,
    parameter int DEPTH        = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                    cmd_valid_in;
    logic                    cmd_ready_out;
    fib_node_pkg::op_e       cmd_op_in;
    logic [POINTER_SIZE-1:0] cmd_ptr_in;
    logic [WORD_SIZE-1:0]    cmd_data_in;
    logic [POINTER_SIZE-1:0] cmd_link_in;
    logic                    rsp_valid_out;
    logic                    rsp_err_out;
    logic [POINTER_SIZE-1:0] rsp_ptr_out;
    logic [WORD_SIZE-1:0]    rsp_data_out;
    logic [POINTER_SIZE-1:0] rsp_left_out;
    logic [POINTER_SIZE-1:0] rsp_right_out;
    logic [2:0]              rsp_flags_out;
    logic [AW:0]             free_count_out;

    modport master (
        output cmd_valid_in, cmd_op_in, cmd_ptr_in, cmd_data_in, cmd_link_in,
        input  cmd_ready_out, rsp_valid_out, rsp_err_out, rsp_ptr_out, rsp_data_out,
               rsp_left_out, rsp_right_out, rsp_flags_out, free_count_out
    );

    modport slave (
        input  cmd_valid_in, cmd_op_in, cmd_ptr_in, cmd_data_in, cmd_link_in,
        output cmd_ready_out, rsp_valid_out, rsp_err_out, rsp_ptr_out, rsp_data_out,
               rsp_left_out, rsp_right_out, rsp_flags_out, free_count_out
    );
endinterface

// File: rtl/fib_node_table_free_stack.sv
// fib_free_stack: LIFO of free node indices. Push on a full stack or pop on
// an empty one is ignored; top_idx is meaningful only when !empty.
module fib_free_stack #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          push,
    input  logic [AW-1:0] push_idx,
    input  logic          pop,
    output logic [AW-1:0] top_idx,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][AW-1:0] stk_q;
    logic [AW:0]              count_q;
    logic [AW-1:0]            top_ptr;

    assign top_ptr = count_q[AW-1:0] - AW'(1);
    assign top_idx = stk_q[top_ptr];
    assign empty   = (count_q == '0);
    assign count   = count_q;

    // Push writes above the current top; pop just drops the top entry.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stk_q   <= '0;
            count_q <= '0;
        end else if (push && count_q != FULL) begin
            stk_q[count_q[AW-1:0]] <= push_idx;
            count_q                <= count_q + 1'b1;
        end else if (pop && !empty) begin
            count_q <= count_q - 1'b1;
        end
    end
endmodule

// File: rtl/fib_node_table.sv
// fib_node_table: DEPTH FIB trie nodes with free-list allocator and a single
// command/response port. Responses are registered, one cycle after accept.
// Optional: FIB_NODE_TABLE_PARITY_EN adds one even-parity bit per node over
// {data,left,right}; a READ that sees a mismatch reports rsp_err_out.
module fib_node_table
    import fib_node_pkg::*;
#(
    parameter int WORD_SIZE    = NODE_WORD_W,
    parameter int POINTER_SIZE = NODE_PTR_W,
    parameter int DEPTH        = 16
) (
    input logic             clk_in,
    input logic             rst_n_in,
    fib_node_table_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [POINTER_SIZE:0] DEPTH_P = (POINTER_SIZE+1)'(DEPTH);

    state_e  state_q;
    logic [AW-1:0] init_idx_q;
    node_t   nodes [DEPTH];
    node_t   cur, upd_node;
    logic [AW-1:0] idx, upd_idx, push_idx, stk_top;
    logic    accept, idx_ok, link_ok, upd_en, push, pop, stk_empty;
    logic [AW:0] stk_count;
    logic    r_err;
    logic [POINTER_SIZE-1:0] r_ptr, r_left, r_right;
    logic [WORD_SIZE-1:0]    r_data;
    logic [2:0]              r_flags;
`ifdef FIB_NODE_TABLE_PARITY_EN
    logic [DEPTH-1:0] par_q;
`endif

    assign bus.cmd_ready_out  = (state_q == ST_RUN);
    assign bus.free_count_out = (state_q == ST_RUN) ? stk_count : '0;
    assign accept  = bus.cmd_valid_in & bus.cmd_ready_out;
    assign idx     = bus.cmd_ptr_in[AW-1:0];
    assign idx_ok  = {1'b0, bus.cmd_ptr_in} < DEPTH_P;
    assign link_ok = {1'b0, bus.cmd_link_in} < DEPTH_P;
    assign cur     = nodes[idx];

    fib_free_stack #(.DEPTH(DEPTH), .AW(AW)) u_stack (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .push     (push),
        .push_idx (push_idx),
        .pop      (pop),
        .top_idx  (stk_top),
        .empty    (stk_empty),
        .count    (stk_count)
    );

    // Decode the accepted command into a node update, stack action and response.
    always_comb begin
        r_err    = 1'b0;
        r_ptr    = bus.cmd_ptr_in;
        r_data   = '0;
        r_left   = '0;
        r_right  = '0;
        r_flags  = '0;
        upd_en   = 1'b0;
        upd_idx  = idx;
        upd_node = cur;
        push     = 1'b0;
        pop      = 1'b0;
        push_idx = idx;
        case (bus.cmd_op_in)
            OP_ALLOC: begin
                r_ptr = '0;
                if (stk_empty) begin
                    r_err = 1'b1;
                end else begin
                    pop            = 1'b1;
                    upd_en         = 1'b1;
                    upd_idx        = stk_top;
                    upd_node       = '0;
                    upd_node.valid = 1'b1;
                    r_ptr          = POINTER_SIZE'(stk_top);
                end
            end
            OP_WRITE: begin
                if (!idx_ok || !cur.valid) r_err = 1'b1;
                else begin
                    upd_en        = 1'b1;
                    upd_node.data = bus.cmd_data_in;
                end
            end
            OP_SET_LEFT: begin
                if (!idx_ok || !cur.valid || !link_ok) r_err = 1'b1;
                else begin
                    upd_en          = 1'b1;
                    upd_node.left   = bus.cmd_link_in;
                    upd_node.lvalid = 1'b1;
                end
            end
            OP_SET_RIGHT: begin
                if (!idx_ok || !cur.valid || !link_ok) r_err = 1'b1;
                else begin
                    upd_en          = 1'b1;
                    upd_node.right  = bus.cmd_link_in;
                    upd_node.rvalid = 1'b1;
                end
            end
            OP_READ: begin
                if (!idx_ok) r_err = 1'b1;
                else begin
                    r_data  = cur.data;
                    r_left  = cur.left;
                    r_right = cur.right;
                    r_flags = {cur.valid, cur.lvalid, cur.rvalid};
`ifdef FIB_NODE_TABLE_PARITY_EN
                    r_err   = (^{cur.data, cur.left, cur.right}) != par_q[idx];
`endif
                end
            end
            OP_FREE: begin
                if (!idx_ok || !cur.valid) r_err = 1'b1;
                else begin
                    upd_en          = 1'b1;
                    upd_node.valid  = 1'b0;
                    upd_node.lvalid = 1'b0;
                    upd_node.rvalid = 1'b0;
                    push            = 1'b1;
                end
            end
            default: r_err = 1'b1;
        endcase
        if (!accept) begin
            upd_en = 1'b0;
            push   = 1'b0;
            pop    = 1'b0;
        end
        // INIT owns the stack push port; no command is accepted then.
        if (state_q == ST_INIT) begin
            push     = 1'b1;
            push_idx = init_idx_q;
        end
    end

    // INIT seeds the free stack with DEPTH-1..0 so index 0 pops first.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_INIT;
            init_idx_q <= AW'(DEPTH - 1);
        end else if (state_q == ST_INIT) begin
            if (init_idx_q == '0) state_q <= ST_RUN;
            else                  init_idx_q <= init_idx_q - 1'b1;
        end
    end

    // Node storage; reset clears every node including its valid bits.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) nodes[i] <= '0;
        end else if (upd_en) begin
            nodes[upd_idx] <= upd_node;
        end
    end

`ifdef FIB_NODE_TABLE_PARITY_EN
    // Parity follows every node update.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)   par_q <= '0;
        else if (upd_en) par_q[upd_idx] <= ^{upd_node.data, upd_node.left, upd_node.right};
    end
`endif

    // Registered response; all fields held at zero when no response.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus.rsp_valid_out <= 1'b0;
            bus.rsp_err_out   <= 1'b0;
            bus.rsp_ptr_out   <= '0;
            bus.rsp_data_out  <= '0;
            bus.rsp_left_out  <= '0;
            bus.rsp_right_out <= '0;
            bus.rsp_flags_out <= '0;
        end else begin
            bus.rsp_valid_out <= accept;
            bus.rsp_err_out   <= accept ? r_err   : 1'b0;
            bus.rsp_ptr_out   <= accept ? r_ptr   : '0;
            bus.rsp_data_out  <= accept ? r_data  : '0;
            bus.rsp_left_out  <= accept ? r_left  : '0;
            bus.rsp_right_out <= accept ? r_right : '0;
            bus.rsp_flags_out <= accept ? r_flags : '0;
        end
    end
endmodule

// File: tb/tb_fib_node_table.sv
// Scoreboard bench for fib_node_table at DEPTH=4, 16-bit words and pointers.
module tb_fib_node_table;
    import fib_node_pkg::*;

    typedef struct {
        logic        err;
        logic [15:0] ptr, data, left, right;
        logic [2:0]  flags;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    fib_node_table_if #(.WORD_SIZE(16), .POINTER_SIZE(16), .DEPTH(4)) bus ();

    fib_node_table #(.WORD_SIZE(16), .POINTER_SIZE(16), .DEPTH(4)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Issue one command and queue its expected response.
    task automatic send(input op_e op, input logic [15:0] ptr, input logic [15:0] data,
                        input logic [15:0] link, input logic e_err, input logic [15:0] e_ptr,
                        input logic [15:0] e_data, input logic [15:0] e_left,
                        input logic [15:0] e_right, input logic [2:0] e_flags, input string nm);
        exp_t e;
        bus.cmd_valid_in = 1'b1;
        bus.cmd_op_in    = op;
        bus.cmd_ptr_in   = ptr;
        bus.cmd_data_in  = data;
        bus.cmd_link_in  = link;
        for (int n = 0; !bus.cmd_ready_out; n++) begin
            if (n >= 50) begin
                checks++; errors++;
                $display("FAIL %s_ready: got timeout expected ready", nm);
                break;
            end
            @(posedge clk); #1;
        end
        e = '{err: e_err, ptr: e_ptr, data: e_data, left: e_left, right: e_right,
              flags: e_flags, name: nm};
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.cmd_valid_in = 1'b0;
        bus.cmd_op_in    = OP_ALLOC;
        bus.cmd_ptr_in   = '0;
        bus.cmd_data_in  = '0;
        bus.cmd_link_in  = '0;
    endtask

    // Monitor: compare each response against the queue head; idle bus must be zero.
    always @(negedge clk) begin
        if (bus.rsp_valid_out) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: got rsp_valid 1 expected 0");
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, ".err"},   32'(bus.rsp_err_out),   32'(mon_e.err));
                chk({mon_e.name, ".ptr"},   32'(bus.rsp_ptr_out),   32'(mon_e.ptr));
                chk({mon_e.name, ".data"},  32'(bus.rsp_data_out),  32'(mon_e.data));
                chk({mon_e.name, ".left"},  32'(bus.rsp_left_out),  32'(mon_e.left));
                chk({mon_e.name, ".right"}, 32'(bus.rsp_right_out), 32'(mon_e.right));
                chk({mon_e.name, ".flags"}, 32'(bus.rsp_flags_out), 32'(mon_e.flags));
            end
        end else begin
            chk("idle_zero", 32'(|{bus.rsp_err_out, bus.rsp_ptr_out, bus.rsp_data_out,
                                   bus.rsp_left_out, bus.rsp_right_out, bus.rsp_flags_out}), 32'd0);
        end
    end

    // Bring the table out of reset and check the INIT timing.
    task automatic do_reset_release(input string nm);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk({nm, "_ready_init"}, 32'(bus.cmd_ready_out), 32'd0);
        chk({nm, "_free_init"},  32'(bus.free_count_out), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_ready_run"},  32'(bus.cmd_ready_out), 32'd1);
        chk({nm, "_free_run"},   32'(bus.free_count_out), 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid_in = 1'b0;
        bus.cmd_op_in    = OP_ALLOC;
        bus.cmd_ptr_in   = '0;
        bus.cmd_data_in  = '0;
        bus.cmd_link_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.cmd_ready_out), 32'd0);
        chk("rst_free",  32'(bus.free_count_out), 32'd0);
        chk("rst_valid", 32'(bus.rsp_valid_out), 32'd0);
        do_reset_release("boot");

        // Allocation order and exhaustion.
        send(OP_ALLOC, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, "alloc0");
        send(OP_ALLOC, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000, "alloc1");
        send(OP_ALLOC, 0, 0, 0, 0, 2, 0, 0, 0, 3'b000, "alloc2");
        send(OP_ALLOC, 0, 0, 0, 0, 3, 0, 0, 0, 3'b000, "alloc3");
        chk("free_after4", 32'(bus.free_count_out), 32'd0);
        send(OP_ALLOC, 0, 0, 0, 1, 0, 0, 0, 0, 3'b000, "alloc_empty");
        chk("free_empty", 32'(bus.free_count_out), 32'd0);
        send(OP_FREE,  2, 0, 0, 0, 2, 0, 0, 0, 3'b000, "free2");
        chk("free_one", 32'(bus.free_count_out), 32'd1);
        send(OP_ALLOC, 0, 0, 0, 0, 2, 0, 0, 0, 3'b000, "realloc2");
        chk("free_zero", 32'(bus.free_count_out), 32'd0);

        // Field updates, write-then-read, link range check.
        send(OP_WRITE,    0, 16'hBEEF, 0, 0, 0, 0, 0, 0, 3'b000, "write0");
        send(OP_SET_LEFT, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, "setl0");
        send(OP_READ,     0, 0, 0, 0, 0, 16'hBEEF, 1, 0, 3'b110, "read0");
        send(OP_WRITE,    1, 16'h1234, 0, 0, 1, 0, 0, 0, 3'b000, "write1");
        send(OP_READ,     1, 0, 0, 0, 1, 16'h1234, 0, 0, 3'b100, "wtr1");
        send(OP_SET_RIGHT, 0, 0, 4, 1, 0, 0, 0, 0, 3'b000, "setr_badlink");
        send(OP_READ,     0, 0, 0, 0, 0, 16'hBEEF, 1, 0, 3'b110, "read0_unch");
        send(OP_SET_RIGHT, 0, 0, 3, 0, 0, 0, 0, 0, 3'b000, "setr0");
        send(OP_READ,     0, 0, 0, 0, 0, 16'hBEEF, 1, 3, 3'b111, "read0_full");

        // Double free and out-of-range indices.
        send(OP_FREE, 3, 0, 0, 0, 3, 0, 0, 0, 3'b000, "free3");
        chk("free_f3", 32'(bus.free_count_out), 32'd1);
        send(OP_FREE, 3, 0, 0, 1, 3, 0, 0, 0, 3'b000, "free3_dbl");
        chk("free_dbl", 32'(bus.free_count_out), 32'd1);
        send(OP_READ,     3, 0, 0, 0, 3, 0, 0, 0, 3'b000, "read_inv3");
        send(OP_WRITE,    5, 16'h5555, 0, 1, 5, 0, 0, 0, 3'b000, "write_oob");
        send(OP_READ,     7, 0, 0, 1, 7, 0, 0, 0, 3'b000, "read_oob");
        send(OP_FREE,     9, 0, 0, 1, 9, 0, 0, 0, 3'b000, "free_oob");
        send(OP_SET_LEFT, 3, 0, 0, 1, 3, 0, 0, 0, 3'b000, "setl_inv3");
        send(OP_FREE,     0, 0, 0, 0, 0, 0, 0, 0, 3'b000, "free0");
        chk("free_f0", 32'(bus.free_count_out), 32'd2);
        send(OP_READ,     0, 0, 0, 0, 0, 16'hBEEF, 1, 3, 3'b000, "read_freed0");

        // Reset between accept and response: the response must vanish.
        bus.cmd_valid_in = 1'b1;
        bus.cmd_op_in    = OP_READ;
        bus.cmd_ptr_in   = 16'd1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.cmd_valid_in = 1'b0;
        bus.cmd_ptr_in   = '0;
        #1;
        chk("midrst_drop", 32'(bus.rsp_valid_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_ready", 32'(bus.cmd_ready_out), 32'd0);
        do_reset_release("rerun");
        send(OP_READ,  0, 0, 0, 0, 0, 0, 0, 0, 3'b000, "read0_after_rst");
        send(OP_ALLOC, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, "alloc_after_rst");
        send(OP_WRITE, 0, 16'hBEEF, 0, 0, 0, 0, 0, 0, 3'b000, "write0_b");

`ifdef FIB_NODE_TABLE_PARITY_EN
        // Stored parity for BEEF is 1; force it wrong so READ reports the mismatch.
        force dut.par_q[0] = 1'b0;
        send(OP_READ, 0, 0, 0, 1, 0, 16'hBEEF, 0, 0, 3'b100, "read_parity");
        repeat (2) @(posedge clk);
        release dut.par_q[0];
`else
        send(OP_READ, 0, 0, 0, 0, 0, 16'hBEEF, 0, 0, 3'b100, "read_noparity");
`endif

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL outstanding: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
